cpu_req_queue: RTL



---
 rtl/mc_pkg.sv | 18 +
 rtl/req_queue_mem.sv | 33 +++
 rtl/cpu_req_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared memory-controller definitions.
// Holds the CPU request word layout and the default queue sizing that the
// request queue and the scheduler both use.
package mc_pkg;

  // Request word: {rw, addr[33:0], data[31:0]}
  localparam int unsigned REQ_W        = 67;
  localparam int unsigned REQ_RW_BIT   = 66;
  localparam int unsigned REQ_ADDR_MSB = 65;
  localparam int unsigned REQ_ADDR_LSB = 32;
  localparam int unsigned REQ_DATA_MSB = 31;
  localparam int unsigned REQ_DATA_LSB = 0;

  // Default CPU request queue sizing
  localparam int unsigned DEFAULT_DEPTH     = 8;
  localparam int unsigned DEFAULT_AF_THRESH = 6;

endpackage

// File: rtl/req_queue_mem.sv
// Storage array for the CPU request queue.
// DEPTH x DATA_W registers, one synchronous write port and one asynchronous
// read port. Contents are not reset.
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module req_queue_mem #(
  parameter int unsigned DATA_W = 67,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_req_queue.sv
// CPU request queue: first-word-fall-through FIFO between the CPU interface
// and the scheduler, with valid/ready on both sides.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : synchronous clear of pointers, count and status
//   in_valid/in_data/in_ready    : CPU side; in_ready = (count < DEPTH)
//   out_valid/out_data/out_ready : scheduler side; out_valid = (count != 0)
//   count       : current occupancy
//   almost_full : count >= AF_THRESH
//   overflow    : sticky, set on a push attempt while full
//   high_water  : maximum occupancy since reset or flush
module cpu_req_queue
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W    = REQ_W,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned AF_THRESH = DEFAULT_AF_THRESH,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              overflow,
  output logic [CNT_W-1:0]  high_water
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_THRESH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] high_water_q, high_water_d;
  logic             overflow_q, overflow_d;

  logic push, pop, mem_we;

  // Status comes straight from registered count, so in_ready never depends
  // on out_ready: a full queue rejects a push even when popping that cycle.
  assign in_ready    = (count_q < DepthCnt);
  assign out_valid   = (count_q != '0);
  assign almost_full = (count_q >= AfCnt);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign high_water  = high_water_q;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign mem_we = push && !flush && !reset;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    high_water_d = high_water_q;

    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      high_water_d = '0;
    end else begin
      // Pointers wrap naturally; DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      if (in_valid && !in_ready) overflow_d = 1'b1;
      if (count_d > high_water_q) high_water_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      high_water_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      high_water_q <= high_water_d;
    end
  end

  req_queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

endmodule
